dm_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the CPU MEM stage (requester 0) and a DMA/debug port (requester 1).
- Sequences each access over a ready-handshake memory interface and stalls the pipeline while the CPU waits.
- Sits between the MEM stage (which supplies word address, byteen and aligned write data) and the data memory/bridge.

---
 rtl/dm_arbiter_pkg.sv | 19 +
 rtl/dm_arbiter_if.sv | 21 ++
 rtl/dm_arbiter_wait_counter.sv | 27 ++
 rtl/dm_arbiter.sv | 127 ++++++++++++
 tb/tb_dm_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// DM_ERR_DATA is the read word returned on a DM_TIMEOUT_EN abort.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_BUSY = 2'd1,
      DMA_BUSY = 2'd2
   } state_t;

   localparam logic [31:0] DM_ERR_DATA    = 32'hDEAD_BEEF;
   localparam logic [3:0]  DM_BYTEEN_READ = 4'b0000;
   localparam logic [31:0] DM_WORD_MASK   = 32'hFFFF_FFFC;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & DM_WORD_MASK;
   endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Ready-handshake data-memory bus between the arbiter (master) and memory/bridge (slave).
interface dm_arbiter_if;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_addr, mem_byteen, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr, mem_byteen, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/dm_arbiter_wait_counter.sv
// Saturating up-counter: clr has priority, inc stops at MAX, sat flags the ceiling.
module dm_wait_counter #(
   parameter int unsigned MAX   = 8,
   parameter int unsigned WIDTH = $clog2(MAX + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   logic [WIDTH-1:0] cnt;

   assign sat = (cnt == WIDTH'(MAX));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the data-memory port between the CPU MEM stage and a DMA/debug port.
// Define DM_TIMEOUT_EN to add the busy-cycle timeout that aborts hung accesses and sets bus_err.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 8
`ifdef DM_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cpu_req,
   input  logic [31:0]  cpu_addr,
   input  logic [3:0]   cpu_byteen,
   input  logic [31:0]  cpu_wdata,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_stall,
   input  logic         dma_req,
   input  logic [31:0]  dma_addr,
   input  logic [3:0]   dma_byteen,
   input  logic [31:0]  dma_wdata,
   output logic [31:0]  dma_rdata,
   output logic         dma_ack,
   dm_arbiter_if.master mem,
   output logic         bus_err
);

   state_t state, state_nxt;
   logic   grant_cpu, grant_dma;
   logic   wait_inc, wait_sat;
   logic   timeout, done;

   // Completion covers both a real mem_ready and a timeout abort.
   assign done = (state != IDLE) && (mem.mem_ready || timeout);

   always_comb begin
      state_nxt = state;
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      unique case (state)
         IDLE: begin
            if (dma_req && (!cpu_req || wait_sat)) begin
               grant_dma = 1'b1;
               state_nxt = DMA_BUSY;
            end else if (cpu_req) begin
               grant_cpu = 1'b1;
               state_nxt = CPU_BUSY;
            end
         end
         CPU_BUSY, DMA_BUSY: begin
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem.mem_req    <= 1'b0;
         mem.mem_addr   <= '0;
         mem.mem_byteen <= '0;
         mem.mem_wdata  <= '0;
      end else if (grant_cpu || grant_dma) begin
         mem.mem_req    <= 1'b1;
         mem.mem_addr   <= word_align(grant_dma ? dma_addr : cpu_addr);
         mem.mem_byteen <= grant_dma ? dma_byteen : cpu_byteen;
         mem.mem_wdata  <= grant_dma ? dma_wdata : cpu_wdata;
      end else if (done) begin
         mem.mem_req    <= 1'b0;
      end
   end

   assign cpu_stall = cpu_req && !((state == CPU_BUSY) && done);
   assign dma_ack   = (state == DMA_BUSY) && done;
   assign cpu_rdata = timeout ? DM_ERR_DATA : mem.mem_rdata;
   assign dma_rdata = timeout ? DM_ERR_DATA : mem.mem_rdata;

   // DMA starvation guard: counts cycles a pending DMA request is passed over.
   assign wait_inc = dma_req && !grant_dma && (state != DMA_BUSY);

   dm_wait_counter #(
      .MAX (MAX_WAIT)
   ) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wait_inc),
      .clr   (grant_dma),
      .sat   (wait_sat)
   );

`ifdef DM_TIMEOUT_EN
   localparam int unsigned TMR_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic busy, tmr_sat;

   assign busy    = (state == CPU_BUSY) || (state == DMA_BUSY);
   assign timeout = busy && tmr_sat && !mem.mem_ready;

   dm_wait_counter #(
      .MAX   (TIMEOUT_CYCLES),
      .WIDTH (TMR_W)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .inc   (busy && !mem.mem_ready),
      .clr   (grant_cpu || grant_dma),
      .sat   (tmr_sat)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       bus_err <= 1'b0;
      else if (timeout) bus_err <= 1'b1;
   end
`else
   assign timeout = 1'b0;
   assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter; memory side modelled by a ready gate
// and an address-derived read pattern.
module tb_dm_arbiter;
   import dm_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [3:0]  cpu_byteen = '0;
   logic [31:0] cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        dma_req = 1'b0;
   logic [31:0] dma_addr = '0;
   logic [3:0]  dma_byteen = '0;
   logic [31:0] dma_wdata = '0;
   logic [31:0] dma_rdata;
   logic        dma_ack;
   logic        bus_err;
   logic        rdy_en = 1'b0;

   int errors = 0;
   int checks = 0;

   dm_arbiter_if mif ();

   assign mif.mem_ready = mif.mem_req & rdy_en;
   assign mif.mem_rdata = mif.mem_addr ^ 32'h5A5A_5A5A;

   dm_arbiter #(
      .MAX_WAIT (8)
`ifdef DM_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_byteen (cpu_byteen),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_byteen (dma_byteen),
      .dma_wdata  (dma_wdata),
      .dma_rdata  (dma_rdata),
      .dma_ack    (dma_ack),
      .mem        (mif.master),
      .bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // reset state
      cyc();
      cyc();
      chk1("rst_mem_req", mif.mem_req, 1'b0);
      chk("rst_mem_addr", mif.mem_addr, 32'h0);
      chk("rst_mem_byteen", 32'(mif.mem_byteen), 32'h0);
      chk("rst_mem_wdata", mif.mem_wdata, 32'h0);
      chk1("rst_bus_err", bus_err, 1'b0);
      chk1("rst_stall", cpu_stall, 1'b0);
      chk1("rst_dma_ack", dma_ack, 1'b0);
      reset = 1'b1;
      cyc();

      // CPU read, ready three cycles after mem_req
      cpu_addr = 32'h0000_1006; cpu_byteen = DM_BYTEEN_READ; cpu_req = 1'b1; rdy_en = 1'b0;
      #1;
      chk1("rd_stall_idle", cpu_stall, 1'b1);
      chk1("rd_req_idle", mif.mem_req, 1'b0);
      cyc(); #1;
      chk("rd_mem_addr", mif.mem_addr, 32'h0000_1004);
      chk1("rd_mem_req", mif.mem_req, 1'b1);
      chk("rd_mem_byteen", 32'(mif.mem_byteen), 32'h0);
      chk1("rd_stall_b1", cpu_stall, 1'b1);
      cyc(); #1;
      chk1("rd_stall_b2", cpu_stall, 1'b1);
      cyc(); rdy_en = 1'b1; #1;
      chk1("rd_stall_done", cpu_stall, 1'b0);
      chk("rd_rdata", cpu_rdata, rd_model(32'h0000_1006));
      cpu_req = 1'b0;
      cyc(); #1;
      chk1("rd_req_after", mif.mem_req, 1'b0);
      chk1("rd_stall_after", cpu_stall, 1'b0);

      // CPU write, immediate ready
      cpu_addr = 32'h0000_2000; cpu_byteen = 4'b1100; cpu_wdata = 32'hABCD_0000; cpu_req = 1'b1;
      #1;
      chk1("wr_stall_idle", cpu_stall, 1'b1);
      cyc(); #1;
      chk("wr_mem_byteen", 32'(mif.mem_byteen), 32'h0000_000C);
      chk("wr_mem_wdata", mif.mem_wdata, 32'hABCD_0000);
      chk("wr_mem_addr", mif.mem_addr, 32'h0000_2000);
      chk1("wr_stall_done", cpu_stall, 1'b0);
      cpu_req = 1'b0;
      cyc(); #1;
      chk1("wr_req_after", mif.mem_req, 1'b0);
      chk1("wr_stall_after", cpu_stall, 1'b0);

      // simultaneous requests: CPU first, then one DMA ack
      cpu_addr = 32'h0000_4000; cpu_byteen = DM_BYTEEN_READ;
      dma_addr = 32'h0000_300A; dma_byteen = DM_BYTEEN_READ;
      cpu_req = 1'b1; dma_req = 1'b1;
      #1;
      chk1("sim_stall_idle", cpu_stall, 1'b1);
      chk1("sim_ack_idle", dma_ack, 1'b0);
      cyc(); #1;
      chk("sim_cpu_addr", mif.mem_addr, 32'h0000_4000);
      chk1("sim_cpu_stall", cpu_stall, 1'b0);
      chk1("sim_ack_cpu", dma_ack, 1'b0);
      chk("sim_cpu_rdata", cpu_rdata, rd_model(32'h0000_4000));
      cpu_req = 1'b0;
      cyc(); #1;
      chk1("sim_req_gap", mif.mem_req, 1'b0);
      chk1("sim_ack_gap", dma_ack, 1'b0);
      cyc(); #1;
      chk("sim_dma_addr", mif.mem_addr, 32'h0000_3008);
      chk1("sim_dma_ack", dma_ack, 1'b1);
      chk("sim_dma_rdata", dma_rdata, rd_model(32'h0000_300A));
      dma_req = 1'b0;
      cyc(); #1;
      chk1("sim_ack_after", dma_ack, 1'b0);
      chk1("sim_req_after", mif.mem_req, 1'b0);

      // starvation: four CPU accesses pass the DMA over, then it is forced through
      dma_addr = 32'h0000_6000; dma_byteen = 4'b0011; dma_wdata = 32'h1234_5678;
      cpu_byteen = DM_BYTEEN_READ; cpu_req = 1'b1; dma_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cpu_addr = 32'h0000_0100 + i * 4;
         #1;
         chk1("stv_stall_idle", cpu_stall, 1'b1);
         cyc(); #1;
         chk("stv_cpu_addr", mif.mem_addr, 32'h0000_0100 + i * 4);
         chk1("stv_cpu_stall", cpu_stall, 1'b0);
         chk1("stv_ack_cpu", dma_ack, 1'b0);
         cyc();
      end
      #1;
      chk1("stv_stall_pre", cpu_stall, 1'b1);
      cyc(); #1;
      chk("stv_dma_addr", mif.mem_addr, 32'h0000_6000);
      chk("stv_dma_byteen", 32'(mif.mem_byteen), 32'h0000_0003);
      chk("stv_dma_wdata", mif.mem_wdata, 32'h1234_5678);
      chk1("stv_dma_ack", dma_ack, 1'b1);
      chk1("stv_stall_dma", cpu_stall, 1'b1);
      dma_req = 1'b0;
      cyc();
      // wait count restarted: CPU wins the next contest again
      cpu_addr = 32'h0000_0200; dma_req = 1'b1;
      #1;
      chk1("stv2_stall_idle", cpu_stall, 1'b1);
      cyc(); #1;
      chk("stv2_cpu_addr", mif.mem_addr, 32'h0000_0200);
      chk1("stv2_ack_cpu", dma_ack, 1'b0);
      cpu_req = 1'b0;
      cyc(); #1;
      chk1("stv2_req_gap", mif.mem_req, 1'b0);
      cyc(); #1;
      chk1("stv2_dma_ack", dma_ack, 1'b1);
      dma_req = 1'b0;
      cyc();

      // reset while in DMA_BUSY
      dma_addr = 32'h0000_5004; dma_byteen = DM_BYTEEN_READ; dma_req = 1'b1; rdy_en = 1'b0;
      #1;
      cyc(); #1;
      chk1("rma_req_busy", mif.mem_req, 1'b1);
      chk1("rma_ack_busy", dma_ack, 1'b0);
      cyc(); #1;
      chk1("rma_req_busy2", mif.mem_req, 1'b1);
      reset = 1'b0;
      #1;
      chk1("rma_req_async", mif.mem_req, 1'b0);
      chk1("rma_ack_async", dma_ack, 1'b0);
      chk("rma_addr_async", mif.mem_addr, 32'h0);
      dma_req = 1'b0;
      cyc();
      reset = 1'b1; rdy_en = 1'b1;
      cpu_addr = 32'h0000_7000; cpu_byteen = DM_BYTEEN_READ; cpu_req = 1'b1;
      #1;
      chk1("rma_req_idle", mif.mem_req, 1'b0);
      chk1("rma_stall_idle", cpu_stall, 1'b1);
      cyc(); #1;
      chk("rma_cpu_addr", mif.mem_addr, 32'h0000_7000);
      chk1("rma_cpu_stall", cpu_stall, 1'b0);
      cpu_req = 1'b0;
      cyc();

`ifdef DM_TIMEOUT_EN
      // timeout: memory never answers
      cpu_addr = 32'h0000_8000; cpu_byteen = DM_BYTEEN_READ; cpu_req = 1'b1; rdy_en = 1'b0;
      #1;
      cyc();
      for (int i = 0; i < 16; i++) begin
         #1;
         chk1("to_stall_busy", cpu_stall, 1'b1);
         cyc();
      end
      #1;
      chk1("to_stall_done", cpu_stall, 1'b0);
      chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk1("to_err_pre", bus_err, 1'b0);
      cpu_req = 1'b0;
      cyc(); #1;
      chk1("to_err_set", bus_err, 1'b1);
      chk1("to_req_drop", mif.mem_req, 1'b0);
      cyc();
      cyc(); #1;
      chk1("to_err_sticky", bus_err, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
